// File: rtl/ecc_rd_monitor_pkg.sv
// Shared types and helpers for the ECC read path: tagged word layout and saturating increment.
package ecc_rd_monitor_pkg;

  localparam int ECC_DATA_W = 32;
  localparam int ECC_PAR_W  = 7;

  typedef struct packed {
    logic [ECC_DATA_W-1:0] data;
    logic                  ded;
  } ecc_word_t;

  // Callers pass the all-ones value of their own counter width as max.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/ecc_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: 1-cycle latency, full throughput,
// in_rdy is registered (skid entry empty) so it never depends combinationally on out_rdy.
module ecc_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_dat_q, main_dat_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         acc;

  assign in_rdy  = ~skid_vld_q;
  assign out_vld = main_vld_q;
  assign out_dat = main_dat_q;
  assign acc     = in_vld & ~skid_vld_q;

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (!main_vld_q || out_rdy) begin
      // Main is free this cycle; the older skid word always wins over new input.
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = acc;
        if (acc) main_dat_d = in_dat;
      end
    end else if (acc) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_dat_q <= main_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/ecc_rd_monitor.sv
// Read-side stage after the SECDED decoder: skid-buffers words and keeps SEC/DED statistics.
// ECC_DROP_DED_EN: when defined, DED words are counted but never forwarded and out_ded is 0.
module ecc_rd_monitor
  import ecc_rd_monitor_pkg::*;
#(
  parameter int DATA_W = ECC_DATA_W,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sec,
  input  logic              in_ded,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ded,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic              ded_irq,
  output logic [ADDR_W-1:0] ded_addr
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);

  ecc_word_t         buf_in, buf_out;
  logic              buf_in_vld;
  logic              accept;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
  logic              ded_irq_q, ded_irq_d;
  logic [ADDR_W-1:0] ded_addr_q, ded_addr_d;

  assign accept = in_valid & in_ready;

`ifdef ECC_DROP_DED_EN
  // in_ready still governs acceptance so a dropped DED word is consumed and counted.
  assign buf_in_vld = in_valid & ~in_ded;
  assign buf_in     = {in_data, 1'b0};
`else
  assign buf_in_vld = in_valid;
  assign buf_in     = {in_data, in_ded};
`endif

  ecc_skid_buf #(.W($bits(ecc_word_t))) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (buf_in_vld),
    .in_rdy  (in_ready),
    .in_dat  (buf_in),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (buf_out)
  );

  assign out_data = buf_out.data;
  assign out_ded  = buf_out.ded;

  always_comb begin
    sec_cnt_d  = sec_cnt_q;
    ded_cnt_d  = ded_cnt_q;
    ded_irq_d  = ded_irq_q;
    ded_addr_d = ded_addr_q;
    // Clear first, then count, so a same-cycle error survives the clear.
    if (clr_cnt) begin
      sec_cnt_d  = '0;
      ded_cnt_d  = '0;
      ded_irq_d  = 1'b0;
      ded_addr_d = '0;
    end
    if (accept && in_sec) sec_cnt_d = CNT_W'(sat_inc(32'(sec_cnt_d), CNT_MAX));
    if (accept && in_ded) begin
      ded_cnt_d = CNT_W'(sat_inc(32'(ded_cnt_d), CNT_MAX));
      if (!ded_irq_d) begin
        ded_irq_d  = 1'b1;
        ded_addr_d = in_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      ded_irq_q  <= 1'b0;
      ded_addr_q <= '0;
    end else begin
      sec_cnt_q  <= sec_cnt_d;
      ded_cnt_q  <= ded_cnt_d;
      ded_irq_q  <= ded_irq_d;
      ded_addr_q <= ded_addr_d;
    end
  end

  assign sec_cnt  = sec_cnt_q;
  assign ded_cnt  = ded_cnt_q;
  assign ded_irq  = ded_irq_q;
  assign ded_addr = ded_addr_q;

endmodule
